// File: rtl/ysyx_25030085_pkg.sv
// Shared definitions for the load/store unit.
// Contents:
//   lsu_state_e  - LSU control FSM states
//   size_e       - decoded access size
//   Funct3*      - funct3 size/sign encodings
//   f3_size()    - funct3 -> access size; the reserved codes 011/110/111 decode as word
package ysyx_25030085_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } size_e;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3BU = 3'b100;
    localparam logic [2:0] Funct3HU = 3'b101;

    // Bit 2 only selects zero-extension, so the low two bits alone fix the size.
    function automatic size_e f3_size(input logic [2:0] f3);
        if (f3[1:0] == Funct3B[1:0]) begin
            return SizeByte;
        end else if (f3[1:0] == Funct3H[1:0]) begin
            return SizeHalf;
        end
        return SizeWord;
    endfunction

endpackage

// File: rtl/ysyx_25030085_lsu_align.sv
// Byte-lane logic for the LSU (purely combinational).
// Ports:
//   addr_lo    in  2   low address bits (byte offset within the word)
//   funct3     in  3   access size/sign
//   store_data in  32  unshifted store value
//   rdata      in  32  read data word from the bus
//   misalign   out 1   access crosses its natural alignment
//   wmask      out 4   byte-lane enables for a store
//   wdata      out 32  store value shifted onto its lanes
//   load_data  out 32  extracted and sign/zero-extended load value
module ysyx_25030085_lsu_align
    import ysyx_25030085_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    size_e       size;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic        zext;

    always_comb begin
        size    = f3_size(funct3);
        shamt   = {addr_lo, 3'b000};
        wdata   = store_data << shamt;
        shifted = rdata >> shamt;
        zext    = funct3[2];
        unique case (size)
            SizeByte: begin
                misalign  = 1'b0;
                wmask     = 4'b0001 << addr_lo;
                load_data = zext ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            SizeHalf: begin
                misalign  = addr_lo[0];
                wmask     = 4'b0011 << addr_lo;
                load_data = zext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misalign  = (addr_lo != 2'b00);
                wmask     = 4'b1111;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: accepts one EXU result at a time, issues at most one bus
// request for it, and hands the writeback value to the WBU.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready                EXU handshake (ready only when idle)
//   alu_result, store_data           effective address / pass-through value, store value
//   mem_ren, mem_wen, funct3, rd     operation decode and destination register
//   req_valid/req_ready, req_*       bus request (word address, write enable/data/mask)
//   resp_valid, resp_rdata           bus response or write ack, read data
//   out_valid/out_ready, out_*       writeback result, destination, misalign flag
module ysyx_25030085_lsu
    import ysyx_25030085_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wmask,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_misalign
);

    lsu_state_e  state;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;

    logic        is_mem;
    logic        is_store;
    logic [1:0]  align_addr_lo;
    logic [2:0]  align_funct3;
    logic        misalign;
    logic [3:0]  lane_wmask;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign in_ready = (state == StIdle);
    assign is_mem   = mem_ren | mem_wen;
    // A request with both enables set is a load.
    assign is_store = mem_wen & ~mem_ren;

    // One lane unit serves both phases: in IDLE it sees the incoming request
    // (store lanes, misalign), afterwards the captured offset/size for the load extract.
    assign align_addr_lo = in_ready ? alu_result[1:0] : addr_lo_q;
    assign align_funct3  = in_ready ? funct3 : funct3_q;

    ysyx_25030085_lsu_align u_align (
        .addr_lo    (align_addr_lo),
        .funct3     (align_funct3),
        .store_data (store_data),
        .rdata      (resp_rdata),
        .misalign   (misalign),
        .wmask      (lane_wmask),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'b000;
            is_load_q    <= 1'b0;
            req_valid    <= 1'b0;
            req_addr     <= 32'h0;
            req_wen      <= 1'b0;
            req_wdata    <= 32'h0;
            req_wmask    <= 4'h0;
            out_valid    <= 1'b0;
            out_data     <= 32'h0;
            out_rd       <= 5'h0;
            out_misalign <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        out_rd    <= rd;
                        addr_lo_q <= alu_result[1:0];
                        funct3_q  <= funct3;
                        is_load_q <= mem_ren;
                        if (!is_mem) begin
                            out_valid    <= 1'b1;
                            out_data     <= alu_result;
                            out_misalign <= 1'b0;
                            state        <= StDone;
                        end else if (misalign) begin
                            // Misaligned accesses never reach the bus.
                            out_valid    <= 1'b1;
                            out_data     <= 32'h0;
                            out_misalign <= 1'b1;
                            state        <= StDone;
                        end else begin
                            req_valid <= 1'b1;
                            req_addr  <= {alu_result[31:2], 2'b00};
                            req_wen   <= is_store;
                            req_wmask <= is_store ? lane_wmask : 4'h0;
                            req_wdata <= is_store ? lane_wdata : 32'h0;
                            state     <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        req_addr  <= 32'h0;
                        req_wen   <= 1'b0;
                        req_wmask <= 4'h0;
                        req_wdata <= 32'h0;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (resp_valid) begin
                        out_valid    <= 1'b1;
                        out_data     <= is_load_q ? load_data : 32'h0;
                        out_misalign <= 1'b0;
                        state        <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        out_data     <= 32'h0;
                        out_rd       <= 5'h0;
                        out_misalign <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
module tb_ysyx_25030085_lsu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_misalign;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    ysyx_25030085_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .funct3       (funct3),
        .rd           (rd),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .req_wmask    (req_wmask),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: behaviour from the size/offset arithmetic rules.
    task automatic model(input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                         input logic ren, input logic wen, input logic [2:0] f3,
                         output bit mem, output bit misal, output logic [31:0] e_addr,
                         output logic [31:0] e_wdata, output logic [3:0] e_mask,
                         output logic e_wen, output logic [31:0] e_out);
        int     nbytes;
        int     off;
        longint v;
        off    = int'(addr % 4);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mem    = ren || wen;
        misal  = mem && ((addr % nbytes) != 0);
        e_addr = addr - off;
        e_wen  = wen && !ren;
        e_mask = e_wen ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
        e_wdata = sd << (8 * off);
        if (!mem) begin
            e_out = addr;
        end else if (misal || e_wen) begin
            e_out = 32'h0;
        end else begin
            v = longint'(rdata >> (8 * off)) % (longint'(1) << (8 * nbytes));
            if (!f3[2] && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1)))
                v = v - (longint'(1) << (8 * nbytes));
            e_out = 32'(v);
        end
    endtask

    task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] rdata,
                          input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [4:0] rdv, input int req_dly, input int resp_dly,
                          input int out_dly);
        bit          mem;
        bit          misal;
        logic [31:0] ea;
        logic [31:0] ew;
        logic [31:0] eo;
        logic [3:0]  em;
        logic        ewen;
        model(alu, sd, rdata, ren, wen, f3, mem, misal, ea, ew, em, ewen, eo);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        alu_result = alu;
        store_data = sd;
        mem_ren    = ren;
        mem_wen    = wen;
        funct3     = f3;
        rd         = rdv;
        @(posedge clk); #1;
        // Garbage on the upstream side must be ignored while busy.
        in_valid   = 1'b0;
        alu_result = $urandom;
        store_data = $urandom;
        mem_ren    = 1'($urandom);
        mem_wen    = 1'($urandom);
        funct3     = 3'($urandom);
        rd         = 5'($urandom);
        check("in_ready_busy", 32'(in_ready), 32'd0);
        if (mem && !misal) begin
            for (int i = 0; i <= req_dly; i++) begin
                check("req_valid", 32'(req_valid), 32'd1);
                check("req_addr", req_addr, ea);
                check("req_wen", 32'(req_wen), 32'(ewen));
                check("req_wmask", 32'(req_wmask), 32'(em));
                if (ewen) check("req_wdata", req_wdata, ew);
                check("out_valid_req", 32'(out_valid), 32'd0);
                check("in_ready_req", 32'(in_ready), 32'd0);
                if (i == req_dly) begin
                    req_ready  = 1'b1;
                    resp_valid = 1'b0;
                end else begin
                    req_ready  = 1'b0;
                    resp_valid = 1'($urandom);
                    resp_rdata = $urandom;
                end
                @(posedge clk); #1;
            end
            req_ready = 1'b0;
            for (int i = 0; i <= resp_dly; i++) begin
                check("req_valid_wait", 32'(req_valid), 32'd0);
                check("out_valid_wait", 32'(out_valid), 32'd0);
                check("in_ready_wait", 32'(in_ready), 32'd0);
                resp_valid = (i == resp_dly);
                resp_rdata = (i == resp_dly) ? rdata : $urandom;
                @(posedge clk); #1;
            end
            resp_valid = 1'b0;
            resp_rdata = $urandom;
        end else begin
            check("no_req", 32'(req_valid), 32'd0);
        end
        for (int i = 0; i <= out_dly; i++) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", out_data, eo);
            check("out_rd", 32'(out_rd), 32'(rdv));
            check("out_misalign", 32'(out_misalign), 32'(misal));
            check("req_valid_done", 32'(req_valid), 32'd0);
            check("in_ready_done", 32'(in_ready), 32'd0);
            in_valid  = (i != out_dly) ? 1'($urandom) : 1'b0;
            out_ready = (i == out_dly);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_cleared", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_req_addr"}, req_addr, 32'd0);
        check({tag, "_req_wen"}, 32'(req_wen), 32'd0);
        check({tag, "_req_wdata"}, req_wdata, 32'd0);
        check({tag, "_req_wmask"}, 32'(req_wmask), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        check({tag, "_out_misalign"}, 32'(out_misalign), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_result = 32'h0;
        store_data = 32'h0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        funct3     = 3'b000;
        rd         = 5'h0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        out_ready  = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // ALU pass-through
        run_op(32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0, 3'b010, 5'd7, 0, 0, 0);
        // LB / LBU at offset 3
        run_op(32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b1, 1'b0, 3'b000, 5'd1, 0, 0, 0);
        run_op(32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b1, 1'b0, 3'b100, 5'd2, 0, 0, 0);
        // SH at offset 2
        run_op(32'h8000_0002, 32'h0000_ABCD, 32'h5555_5555, 1'b0, 1'b1, 3'b001, 5'd3, 0, 0, 0);
        // Backpressure on both sides
        run_op(32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 3'b010, 5'd4, 3, 1, 2);
        // Misaligned LW
        run_op(32'h8000_0002, 32'h0, 32'h0, 1'b1, 1'b0, 3'b010, 5'd5, 0, 0, 0);
        // Both enables set behaves as a load; funct3 111 is a word access
        run_op(32'h0000_0102, 32'h1111_1111, 32'h8765_4321, 1'b1, 1'b1, 3'b001, 5'd6, 0, 0, 0);
        run_op(32'h0000_0200, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b1, 3'b111, 5'd8, 1, 0, 0);

        // Reset while waiting for the response
        in_valid   = 1'b1;
        alu_result = 32'h8000_0004;
        mem_ren    = 1'b1;
        mem_wen    = 1'b0;
        funct3     = 3'b010;
        rd         = 5'd9;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        req_ready = 1'b1;
        @(posedge clk); #1;
        req_ready = 1'b0;
        check("wait_reached_req_valid", 32'(req_valid), 32'd0);
        check("wait_reached_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        rst_n      = 1'b1;
        resp_valid = 1'b1;
        resp_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        check("late_resp_out_valid", 32'(out_valid), 32'd0);
        check("late_resp_req_valid", 32'(req_valid), 32'd0);
        check("late_resp_in_ready", 32'(in_ready), 32'd1);
        run_op(32'h8000_0001, 32'h0, 32'h0000_FE00, 1'b1, 1'b0, 3'b000, 5'd10, 0, 0, 0);

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            run_op($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom),
                   5'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
